sensor_lane_emitter: RTL and testbench

- Synthetic multi-lane sensor source: generates `D` lanes of 12-bit pixel data with per-lane `px_en`/`px_vs`.
- Drives the sensor-side input of the lane alignment stage.
- Full frame timing, deterministic ramp pattern, programmable per-lane skew.
- Used for bring-up and regression of the receive path without a physical sensor.

---
 rtl/sensor_lane_emitter.sv | 141 ++++++++++++++
 tb/tb_sensor_lane_emitter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/sensor_lane_emitter.sv
// sensor_lane_emitter: synthetic D-lane sensor source with frame timing and a ramp pattern.
// Define SENSOR_EMU_LANE_SKEW_EN to build the per-lane skew shift registers.
module sensor_lane_emitter #(
   parameter int    D     = 4,
   parameter string DEBUG = "FALSE"
) (
   input  logic            px_clk,
   input  logic            px_reset,
   input  logic [15:0]     ACTIVE_WIDTH,
   input  logic [15:0]     ACTIVE_HEIGHT,
   input  logic [15:0]     H_BLANK,
   input  logic [15:0]     V_BLANK,
   input  logic [4*D-1:0]  lane_skew,
   input  logic            stream_on_in,
   output logic [12*D-1:0] px_data,
   output logic [D-1:0]    px_en_out,
   output logic [D-1:0]    px_vs_out,
   output logic            frame_done
);
   typedef enum logic [1:0] {IDLE, VBLANK, ACTIVE, HBLANK} state_t;
   (* mark_debug = DEBUG *) state_t state_q;
   state_t state_d;
   (* mark_debug = DEBUG *) logic [15:0] col_q, line_q, cnt_q;
   logic [15:0] col_d, line_d, cnt_d, aw_q, ah_q, hb_q;
   (* mark_debug = DEBUG *) logic fd_q;
   logic fd_d, load, start, unused_dbg;
   logic [13:0] stage [D];
   logic [13:0] tap [D];
   assign unused_dbg = (DEBUG == "TRUE");
   assign start = stream_on_in && |ACTIVE_WIDTH && |ACTIVE_HEIGHT;
   always_ff @(posedge px_clk) begin
      if (px_reset) state_q <= IDLE;
      else state_q <= state_d;
   end
   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      line_d  = line_q;
      cnt_d   = cnt_q;
      fd_d    = 1'b0;
      load    = 1'b0;
      case (state_q)
         IDLE: load = start;
         VBLANK: begin
            if (cnt_q == 16'd0) begin
               state_d = ACTIVE;
               col_d   = 16'd0;
            end else cnt_d = cnt_q - 16'd1;
         end
         ACTIVE: begin
            if (col_q == aw_q - 16'd1) begin
               state_d = HBLANK;
               cnt_d   = (hb_q == 16'd0) ? 16'd0 : hb_q - 16'd1;
            end else col_d = col_q + 16'd1;
         end
         HBLANK: begin
            if (cnt_q != 16'd0) cnt_d = cnt_q - 16'd1;
            else begin
               line_d = line_q + 16'd1;
               if (line_q + 16'd1 < ah_q) begin
                  state_d = ACTIVE;
                  col_d   = 16'd0;
               end else begin
                  fd_d    = 1'b1;
                  state_d = IDLE;
                  load    = start;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (load) begin
         state_d = VBLANK;
         line_d  = 16'd0;
         cnt_d   = (V_BLANK == 16'd0) ? 16'd0 : V_BLANK - 16'd1;
      end
   end
   always_ff @(posedge px_clk) begin
      if (px_reset) begin
         col_q  <= '0;
         line_q <= '0;
         cnt_q  <= '0;
         aw_q   <= '0;
         ah_q   <= '0;
         hb_q   <= '0;
         fd_q   <= 1'b0;
      end else begin
         col_q  <= col_d;
         line_q <= line_d;
         cnt_q  <= cnt_d;
         fd_q   <= fd_d;
         if (load) begin
            aw_q <= ACTIVE_WIDTH;
            ah_q <= ACTIVE_HEIGHT;
            hb_q <= H_BLANK;
         end
      end
   end
   // {vs, en, data} per lane before skew
   always_comb begin
      for (int i = 0; i < D; i++)
         stage[i] = {state_q inside {ACTIVE, HBLANK}, state_q == ACTIVE,
                     (state_q == ACTIVE) ? 12'(line_q + col_q * 16'(D) + 16'(i)) : 12'd0};
   end
`ifdef SENSOR_EMU_LANE_SKEW_EN
   logic [13:0] sr_q [D][16];
   logic [4*D-1:0] skew_q;
   always_ff @(posedge px_clk) begin
      if (px_reset) begin
         skew_q <= '0;
         for (int i = 0; i < D; i++)
            for (int k = 0; k < 16; k++) sr_q[i][k] <= '0;
      end else begin
         if (load) skew_q <= lane_skew;
         for (int i = 0; i < D; i++) begin
            sr_q[i][0] <= stage[i];
            for (int k = 1; k < 16; k++) sr_q[i][k] <= sr_q[i][k-1];
         end
      end
   end
   always_comb begin
      for (int i = 0; i < D; i++) tap[i] = sr_q[i][skew_q[4*i +: 4]];
   end
`else
   logic [13:0] sr_q [D];
   logic unused_skew;
   assign unused_skew = ^lane_skew;
   always_ff @(posedge px_clk) begin
      for (int i = 0; i < D; i++) sr_q[i] <= px_reset ? 14'd0 : stage[i];
   end
   always_comb begin
      for (int i = 0; i < D; i++) tap[i] = sr_q[i];
   end
`endif
   for (genvar g = 0; g < D; g++) begin : g_lane
      assign px_data[12*g +: 12] = tap[g][11:0];
      assign px_en_out[g]        = tap[g][12];
      assign px_vs_out[g]        = tap[g][13];
   end
   assign frame_done = fd_q;
endmodule

// File: tb/tb_sensor_lane_emitter.sv
// tb_sensor_lane_emitter: randomized bench against a frame-position reference model.
module tb_sensor_lane_emitter;
   localparam int D = 4;
   localparam int W = 12*D + 2;
   logic px_clk = 1'b0, px_reset = 1'b1, stream_on_in = 1'b0;
   logic [15:0] aw = '0, ah = '0, hb = '0, vb = '0;
   logic [4*D-1:0] lane_skew = '0;
   logic [12*D-1:0] px_data;
   logic [D-1:0] px_en_out, px_vs_out;
   logic frame_done;
   int vectors = 0, miscompares = 0;
   always #5 px_clk = ~px_clk;
   sensor_lane_emitter #(.D(D)) dut (
      .px_clk(px_clk), .px_reset(px_reset),
      .ACTIVE_WIDTH(aw), .ACTIVE_HEIGHT(ah), .H_BLANK(hb), .V_BLANK(vb),
      .lane_skew(lane_skew), .stream_on_in(stream_on_in),
      .px_data(px_data), .px_en_out(px_en_out), .px_vs_out(px_vs_out),
      .frame_done(frame_done)
   );
   // model: position p inside the current frame, history of undelayed words (newest first)
   logic [W-1:0] hq [$];
   logic [W-1:0] tw;
   bit run = 0, chk_on = 0;
   int p = 0, m_aw = 0, m_ah = 0, m_hb = 1, m_vb = 1, flen = 0;
   int m_skew [D] = '{default: 0};
   logic [12*D-1:0] exp_data = '0;
   logic [D-1:0] exp_en = '0, exp_vs = '0;
   logic exp_fd = 1'b0;
   function automatic logic [W-1:0] pixel_word();
      logic [W-1:0] w;
      int q, c;
      w = '0;
      if (run && p >= m_vb) begin
         q = p - m_vb;
         c = q % (m_aw + m_hb);
         w[W-1] = 1'b1;
         if (c < m_aw) begin
            w[W-2] = 1'b1;
            for (int i = 0; i < D; i++) w[12*i +: 12] = 12'((q / (m_aw + m_hb) + c * D + i) % 4096);
         end
      end
      return w;
   endfunction
   function automatic bit at_col4();
      return run && m_aw > 4 && p >= m_vb && ((p - m_vb) % (m_aw + m_hb)) == 4;
   endfunction
   always @(posedge px_clk) begin
      if (px_reset) begin
         run = 0;
         exp_fd = 1'b0;
         hq.delete();
         for (int k = 0; k < 16; k++) hq.push_back('0);
         for (int i = 0; i < D; i++) m_skew[i] = 0;
      end else begin
         hq.push_front(pixel_word());
         void'(hq.pop_back());
         exp_fd = run && p == flen - 1;
         if (!run || p == flen - 1) begin
            run = stream_on_in && aw != 0 && ah != 0;
            if (run) begin
               p = 0;
               m_aw = aw;
               m_ah = ah;
               m_hb = (hb == 0) ? 1 : int'(hb);
               m_vb = (vb == 0) ? 1 : int'(vb);
               flen = m_vb + m_ah * (m_aw + m_hb);
`ifdef SENSOR_EMU_LANE_SKEW_EN
               for (int i = 0; i < D; i++) m_skew[i] = int'(lane_skew[4*i +: 4]);
`endif
            end
         end else p++;
      end
      for (int i = 0; i < D; i++) begin
         tw = hq[m_skew[i]];
         exp_data[12*i +: 12] = tw[12*i +: 12];
         exp_en[i] = tw[W-2];
         exp_vs[i] = tw[W-1];
      end
   end
   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   always @(negedge px_clk) begin
      if (chk_on) begin
         check_eq("data", 64'(px_data), 64'(exp_data));
         check_eq("en", 64'(px_en_out), 64'(exp_en));
         check_eq("vs", 64'(px_vs_out), 64'(exp_vs));
         check_eq("frame_done", 64'(frame_done), 64'(exp_fd));
      end
   end
   task automatic cycles(input int n);
      repeat (n) @(negedge px_clk);
   endtask
   initial begin
      int fd_n, en_n, vs_n, n;
      cycles(2);
      check_eq("rst_data", 64'(px_data), 64'd0);
      check_eq("rst_en", 64'(px_en_out | px_vs_out), 64'd0);
      check_eq("rst_fd", 64'(frame_done), 64'd0);
      px_reset = 1'b0;
      chk_on = 1;
      // frame timing: 8x3, hblank 4, vblank 5 -> 41-cycle frames
      aw = 16'd8; ah = 16'd3; hb = 16'd4; vb = 16'd5; stream_on_in = 1'b1;
      fd_n = 0; en_n = 0; vs_n = 0;
      repeat (84) begin
         @(negedge px_clk);
         fd_n += int'(frame_done);
         en_n += int'(px_en_out[0]);
         vs_n += int'(px_vs_out[0]);
      end
      check_eq("fd_count", 64'(fd_n), 64'd2);
      check_eq("en_count", 64'(en_n), 64'd48);
      check_eq("vs_count", 64'(vs_n), 64'd72);
      // skew: lanes 3..0 = 3,0,2,1
      lane_skew = {4'd3, 4'd0, 4'd2, 4'd1};
      cycles(84);
      n = 0;
      while (px_en_out != '0 && n < 100) begin @(negedge px_clk); n++; end
      while (px_en_out == '0 && n < 100) begin @(negedge px_clk); n++; end
      check_eq("skew_wait", 64'(n < 100), 64'd1);
`ifdef SENSOR_EMU_LANE_SKEW_EN
      check_eq("skew_e0", 64'(px_en_out), 64'b0100);
      cycles(1);
      check_eq("skew_e1", 64'(px_en_out), 64'b0101);
      cycles(1);
      check_eq("skew_e2", 64'(px_en_out), 64'b0111);
      cycles(1);
      check_eq("skew_e3", 64'(px_en_out), 64'b1111);
`else
      check_eq("skew_e0", 64'(px_en_out), 64'b1111);
`endif
      cycles(60);
      // stream stop mid-frame
      cycles(25);
      stream_on_in = 1'b0;
      cycles(60);
      vs_n = 0;
      repeat (20) begin @(negedge px_clk); vs_n += int'(|px_vs_out) + int'(frame_done); end
      check_eq("idle_quiet", 64'(vs_n), 64'd0);
      // reset at column 4
      stream_on_in = 1'b1;
      n = 0;
      while (!at_col4() && n < 200) begin @(negedge px_clk); n++; end
      check_eq("col4_wait", 64'(n < 200), 64'd1);
      px_reset = 1'b1;
      cycles(1);
      check_eq("mid_rst", 64'(px_data) | 64'(px_en_out) | 64'(px_vs_out) | 64'(frame_done), 64'd0);
      px_reset = 1'b0;
      cycles(60);
      // degenerate: zero height stays idle, zero hblank gives a 1-cycle gap
      ah = 16'd0;
      cycles(60);
      en_n = 0;
      repeat (30) begin @(negedge px_clk); en_n += int'(|px_vs_out); end
      check_eq("zero_height", 64'(en_n), 64'd0);
      ah = 16'd3; hb = 16'd0;
      cycles(80);
      // randomized configuration, stream and reset activity
      repeat (2500) begin
         @(negedge px_clk);
         px_reset = ($urandom_range(299) == 0);
         if ($urandom_range(39) == 0) stream_on_in = ~stream_on_in;
         if ($urandom_range(29) == 0) begin
            aw = 16'($urandom_range(6));
            ah = 16'($urandom_range(4));
            hb = 16'($urandom_range(3));
            vb = 16'($urandom_range(3));
            lane_skew = 16'($urandom);
         end
      end
      @(negedge px_clk);
      chk_on = 0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
